// File: rtl/csl_sequencer.sv
// Column-select-line sequencer: settle, pulse a column or a read group, recover; optional burst over all groups.
// Latency accept->done = SETTLE_CYC+PULSE_CYC+1 per group; req_ready only in IDLE; CSL_in low aborts.
module csl_sequencer #(
  parameter int NWORD      = 6,
  parameter int NGRP       = 3,
  parameter int SETTLE_CYC = 2,
  parameter int PULSE_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_burst,
  input  logic [NWORD-1:0]      req_adr,
  input  logic                  CSL_in,
  output logic [2**NWORD-1:0]   CSL_out,
  output logic                  sense_strobe,
  output logic [NGRP-1:0]       grp_idx,
  output logic                  done,
  output logic                  abort
);

  localparam int NCOL = 2**NWORD;
  localparam int B    = 2**(NWORD-NGRP);
  localparam int CMAX = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int CW   = $clog2(CMAX+1);
  localparam logic [NCOL-1:0] GRP_MASK = {{(NCOL-B){1'b0}}, {B{1'b1}}};

  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, RECOVER} state_t;

  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [NGRP-1:0]   r_grp, w_grp;
  logic [NGRP-1:0]   r_left, w_left;
  logic              r_read, w_read;
  logic [NWORD-1:0]  r_adr, w_adr;
  logic [NCOL-1:0]   r_csl, w_csl;
  logic              r_strobe, w_strobe;
  logic              r_done, w_done;
  logic              r_abort, w_abort;
  logic [NCOL-1:0]   w_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_grp    <= '0;
      r_left   <= '0;
      r_read   <= 1'b0;
      r_adr    <= '0;
      r_csl    <= '0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_grp    <= w_grp;
      r_left   <= w_left;
      r_read   <= w_read;
      r_adr    <= w_adr;
      r_csl    <= w_csl;
      r_strobe <= w_strobe;
      r_done   <= w_done;
      r_abort  <= w_abort;
    end
  end

  // Select pattern for the current operation: a group of B adjacent columns on read, one column on program.
  always_comb begin
    if (r_read) w_pat = GRP_MASK << (int'(r_grp) * B);
    else        w_pat = NCOL'(1) << r_adr;
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_grp    = r_grp;
    w_left   = r_left;
    w_read   = r_read;
    w_adr    = r_adr;
    w_csl    = '0;
    w_strobe = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    if (r_state != IDLE && !CSL_in) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_abort = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && CSL_in) begin
            w_state = SETTLE;
            w_cnt   = CW'(SETTLE_CYC-1);
            w_read  = req_read;
            w_adr   = req_adr;
            w_grp   = req_adr[NGRP-1:0];
            w_left  = (req_read && req_burst) ? '1 : '0;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            w_state = ACTIVE;
            w_cnt   = CW'(PULSE_CYC-1);
          end else begin
            w_cnt = r_cnt - 1'b1;
          end
        end
        ACTIVE: begin
          // CSL_out and the strobe are registered, so they trail the state by one cycle.
          w_csl = w_pat;
          if (r_cnt == '0) begin
            w_state  = RECOVER;
            w_strobe = r_read;
          end else begin
            w_cnt = r_cnt - 1'b1;
          end
        end
        RECOVER: begin
          if (r_left == '0) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end else begin
            w_state = SETTLE;
            w_cnt   = CW'(SETTLE_CYC-1);
            w_left  = r_left - 1'b1;
            w_grp   = r_grp + 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign CSL_out      = r_csl;
  assign sense_strobe = r_strobe;
  assign grp_idx      = r_grp;
  assign done         = r_done;
  assign abort        = r_abort;

endmodule
